keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
- Drives the 4x4 matrix keypad attached to the e902 SoC. One active-low row is driven at a time; the active-low col_in lines are sampled on each row.
- A 16-bit snapshot is built per frame and debounced. Press and release events are queued in a small FIFO that the CPU-side peripheral register logic reads.
- Sits between the SoC top-level pins (row, col_in) and the APB keypad register block.

Parameters:
- SCAN_DIV, 1000: clk cycles each row is held active. Legal range is 8 or more.
- DEBOUNCE_FRAMES, 4: number of consecutive identical frame snapshots required before the debounced state is committed. Legal range is 1 or more.
- FIFO_DEPTH, 4: event FIFO entries. Must be a power of 2 and 2 or more.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- col_in  in  4  column inputs, active-low, asynchronous to clk
- row  out  4  row drive, one-hot active-low
- key_state  out  16  debounced pressed map; bit index = key code
- evt_valid  out  1  FIFO not empty
- evt_data  out  5  head event: {release, code[3:0]}
- evt_rd  in  1  pop request; pops when evt_valid && evt_rd
- evt_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky flag: event dropped because FIFO was full
- ovf_clr  in  1  clears overflow

Behaviour:
- Reset values: row=4'b1110, key_state=0, evt_valid=0, evt_data=0, evt_count=0, overflow=0. All internal counters, the candidate snapshot and the FSM are also reset. Reset mid-emit discards pending events.
- Key code mapping: code = {r[1:0], c[1:0]}.
  - r is the active row index; row==4'b1110 means r=0, 4'b0111 means r=3.
  - c is the col_in bit index that reads 0.
  - Example: row 4'b1101 with col_in 4'b1101 gives code 5.
- col_in passes through a 2-flop synchronizer. It is sampled on the last cycle of each row dwell (divider == SCAN_DIV-1), giving at least 5 cycles of settle time.
- Row sequencing:
  - The divider counts 0..SCAN_DIV-1.
  - On wrap, row rotates left: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  - Scanning runs continuously and independently of the FSM.
- Snapshot: sample bits ~col_sync are written to snap[4r+3:4r]. A frame ends at the sample of row 3.
- Debounce, at frame end:
  - If snap != cand: cand<=snap, cnt<=1.
  - Otherwise cnt<=min(cnt+1, DEBOUNCE_FRAMES).
  - Commit occurs when the effective count (1 if cand changed, else cnt+1) reaches DEBOUNCE_FRAMES and cand differs from key_state.
  - On commit: key_state<=new value; chg<=new ^ old; FSM goes to EMIT.
- FSM states: IDLE, EMIT.
  - IDLE -> EMIT on commit.
  - EMIT walks idx 0..15, one index per clk. If chg[idx], it pushes {~key_state[idx], idx}: press gives release=0, release gives release=1.
  - After idx 15, EMIT -> IDLE. EMIT always lasts 16 cycles.
  - The SCAN_DIV of 8 or more guarantees EMIT finishes before the next frame end.
- FIFO:
  - Synchronous. evt_data shows the head combinationally from the register array.
  - Push and pop in the same cycle when full: both occur and the count is unchanged.
  - Push when full without a pop: the event is dropped and overflow<=1.
  - Pop when empty: ignored.
  - If ovf_clr and a new drop occur in the same cycle, overflow ends at 1 (set wins).
- Event latency: a press stable from the start of frame k appears in key_state at the end of frame k+DEBOUNCE_FRAMES-1. evt_valid rises by idx+2 cycles after commit.
- Multiple simultaneous changes are emitted in ascending code order.
- Ghost or multi-key combinations are reported as sampled, with no masking.

Decomposition:
- Shared package keypad_pkg holds:
  - state enum {IDLE, EMIT}
  - localparams ROW_IDLE=4'b1110, KEYS=16, EVT_W=5
  - event field offsets (release bit 4, code bits 3:0)
- Sub-module kp_event_fifo (parameterised on depth and width) is instantiated once. It is reusable for the UART RX queue.

Test Plan (SCAN_DIV=8, DEBOUNCE_FRAMES=2, FIFO_DEPTH=4; keypad model closes the selected col only while its row is low, released = all 1s):
- Reset held 5 cycles then released -> row=1110, key_state=0, evt_valid=0. Row is 1101 after 8 cycles and back to 1110 after 32 cycles.
- Press key 5 held steady -> key_state=16'h0020 after the 2nd full frame. evt_data=5'h05, evt_count=1. Pop clears evt_valid.
- Release key 5 -> key_state=0 and evt_data=5'h15.
- Key 4 pressed, then switched to key 6 within one frame -> no event for key 4. key_state=16'h0040 and a single press event 5'h06 (plus 5'h14 only if key 4 was committed first).
- Bouncing col toggling every frame for 6 frames -> key_state unchanged, no events.
- Keys 0,1,2,3 and then c,d,e,f forced pressed together with no pops -> 4 events (codes 0,1,2,3) queued, overflow=1, evt_count=4. ovf_clr clears overflow. Simultaneous pop plus push when full keeps the count at 4.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
// Event layout is {release, code[3:0]}.
package keypad_pkg;

  typedef enum logic {
    IDLE,
    EMIT
  } kp_state_t;

  localparam logic [3:0] ROW_IDLE = 4'b1110;
  localparam int KEYS = 16;
  localparam int EVT_W = 5;
  localparam int EVT_REL = 4;
  localparam int EVT_CODE_HI = 3;
  localparam int EVT_CODE_LO = 0;

endpackage

// File: rtl/kp_event_fifo.sv
// Small synchronous FIFO with combinational head and drop pulse.
// A push into a full FIFO only lands when a pop frees a slot that cycle.
module kp_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic [AW:0]      count,
  output logic             drop
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic full;
  logic do_push;
  logic do_pop;

  assign valid = (count != '0);
  assign full = (count == (AW+1)'(DEPTH));
  assign do_pop = pop && valid;
  assign do_push = push && (!full || do_pop);
  assign drop = push && full && !do_pop;
  assign rdata = valid ? mem[rp] : '0;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wp] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wp <= wp + AW'(1);
      end
      if (do_pop) begin
        rp <= rp + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10: count <= count + (AW+1)'(1);
        2'b01: count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner with frame debounce and press/release queue.
// Rows rotate every SCAN_DIV cycles; a frame ends at the row 3 sample.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    col_in,
  output logic [3:0]                    row,
  output logic [KEYS-1:0]               key_state,
  output logic                          evt_valid,
  output logic [EVT_W-1:0]              evt_data,
  input  logic                          evt_rd,
  output logic [$clog2(FIFO_DEPTH):0]   evt_count,
  output logic                          overflow,
  input  logic                          ovf_clr
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1) + 1;

  logic [3:0] col_s1;
  logic [3:0] col_s2;
  logic [DW-1:0] div;
  logic [1:0] ridx;
  logic last;
  logic frame_end;

  logic [KEYS-1:0] snap;
  logic [KEYS-1:0] snap_nxt;
  logic [KEYS-1:0] cand;
  logic [CW-1:0] cnt;
  logic [CW-1:0] eff;
  logic same;
  logic commit;

  kp_state_t state;
  kp_state_t state_nxt;
  logic [3:0] idx;
  logic [KEYS-1:0] chg;
  logic push;
  logic [EVT_W-1:0] evt_w;
  logic drop;

  assign last = (div == DW'(SCAN_DIV - 1));
  assign frame_end = last && (ridx == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_s1 <= 4'hf;
      col_s2 <= 4'hf;
    end else begin
      col_s1 <= col_in;
      col_s2 <= col_s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
      ridx <= 2'd0;
      row <= ROW_IDLE;
    end else if (last) begin
      div <= '0;
      ridx <= ridx + 2'd1;
      row <= {row[2:0], row[3]};
    end else begin
      div <= div + DW'(1);
    end
  end

  // The frame-end snapshot must include the row 3 sample taken this cycle.
  always_comb begin
    snap_nxt = snap;
    if (last) begin
      snap_nxt[{ridx, 2'b00} +: 4] = ~col_s2;
    end
  end

  assign same = (snap_nxt == cand);
  assign eff = same ? cnt + CW'(1) : CW'(1);
  assign commit = frame_end
               && (eff >= CW'(DEBOUNCE_FRAMES))
               && (snap_nxt != key_state)
               && (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap <= '0;
      cand <= '0;
      cnt <= '0;
    end else begin
      snap <= snap_nxt;
      if (frame_end) begin
        if (!same) begin
          cand <= snap_nxt;
          cnt <= CW'(1);
        end else if (eff > CW'(DEBOUNCE_FRAMES)) begin
          cnt <= CW'(DEBOUNCE_FRAMES);
        end else begin
          cnt <= eff;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    push = 1'b0;
    evt_w = '0;
    evt_w[EVT_REL] = ~key_state[idx];
    evt_w[EVT_CODE_HI:EVT_CODE_LO] = idx;
    unique case (state)
      IDLE: begin
        if (commit) begin
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        push = chg[idx];
        if (idx == 4'd15) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx <= 4'd0;
      chg <= '0;
      key_state <= '0;
    end else begin
      state <= state_nxt;
      idx <= (state == EMIT) ? idx + 4'd1 : 4'd0;
      if (commit) begin
        key_state <= snap_nxt;
        chg <= snap_nxt ^ key_state;
      end
    end
  end

  kp_event_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(EVT_W)
  ) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .wdata(evt_w),
    .pop(evt_rd),
    .rdata(evt_data),
    .valid(evt_valid),
    .count(evt_count),
    .drop(drop)
  );

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule
